ss_src_pack_fifo: RTL and testbench

- Upstream feeder for the DMA engine's source port (m_src_*).
- Accepts the 32-bit slave-stream data (ss_xfer/wbs_dat_o/ss_last) and packs word pairs into 64-bit entries.
- Buffers the entries in a first-word-fall-through FIFO with a per-entry last flag, and presents them on the active-low m_src_getn read interface.
- Generates ss_stop backpressure toward the stream source.

---
 rtl/ss_src_pack_fifo.sv | 127 ++++++++++++
 tb/tb_ss_src_pack_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ss_src_pack_fifo.sv
// Packs 32-bit slave-stream words into 64-bit entries and buffers them in a
// first-word-fall-through FIFO feeding the DMA source port.
module ss_src_pack_fifo #(
  parameter int AW       = 4,
  parameter int AE_LEVEL = 2,
  parameter int AF_FREE  = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          m_reset1,
  input  logic          ss_xfer,
  input  logic          ss_last,
  input  logic [31:0]   wbs_dat_o,
  output logic          ss_stop,
  input  logic          m_src_getn,
  output logic [63:0]   m_src,
  output logic          m_src_last,
  output logic          m_src_empty,
  output logic          m_src_almost_empty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          unf
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   AE_C     = AE_LEVEL[AW:0];
  localparam logic [AW:0]   AF_C     = AF_FREE[AW:0];

  typedef enum logic {HALF0, HALF1} pack_state_t;

  pack_state_t   pack_state;
  logic [31:0]   held;
  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          stop_q;
  logic          stop_nxt;
  logic          full;
  logic          empty;
  logic          wr_req;
  logic          pop_req;
  logic          do_wr;
  logic          do_pop;
  logic [64:0]   wr_entry;
  logic [64:0]   head;

  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    wr_req   = ss_xfer && !m_reset1 && ((pack_state == HALF1) || ss_last);
    wr_entry = (pack_state == HALF1) ? {wbs_dat_o, held, ss_last}
                                     : {32'h0, wbs_dat_o, 1'b1};
    pop_req  = !m_src_getn && !m_reset1;
    do_pop   = pop_req && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    do_wr    = wr_req && (!full || do_pop);
    count_nxt = count;
    case ({do_wr, do_pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
    stop_nxt = ((FULL_CNT - count_nxt) <= AF_C);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pack_state <= HALF0;
      held       <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      stop_q     <= 1'b1;
    end else if (m_reset1) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pack_state <= HALF0;
      held       <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      count  <= count_nxt;
      stop_q <= stop_nxt;
      if (wr_req && full && !do_pop) ovf <= 1'b1;
      if (pop_req && empty)          unf <= 1'b1;
      case (pack_state)
        HALF0: begin
          if (ss_xfer && !ss_last) begin
            held       <= wbs_dat_o;
            pack_state <= HALF1;
          end
        end
        HALF1: begin
          if (ss_xfer) pack_state <= HALF0;
        end
        default: pack_state <= HALF0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_wr) mem[wr_ptr] <= wr_entry;
  end

  // Head and flags come only from registered state; m_reset1 forces stop at once.
  always_comb begin
    head               = mem[rd_ptr];
    m_src              = empty ? 64'h0 : head[64:1];
    m_src_last         = !empty && head[0];
    m_src_empty        = empty;
    m_src_almost_empty = (count <= AE_C);
    level              = count;
    ss_stop            = stop_q | m_reset1;
  end

endmodule

// File: tb/tb_ss_src_pack_fifo.sv
// Randomized and directed bench for ss_src_pack_fifo against a queue-based
// model of the packer and FIFO.
module tb_ss_src_pack_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        m_reset1 = 1'b0;
  logic        ss_xfer = 1'b0;
  logic        ss_last = 1'b0;
  logic [31:0] wbs_dat_o = 32'h0;
  logic        ss_stop;
  logic        m_src_getn = 1'b1;
  logic [63:0] m_src;
  logic        m_src_last;
  logic        m_src_empty;
  logic        m_src_almost_empty;
  logic [AW:0] level;
  logic        ovf;
  logic        unf;

  int checks = 0;
  int errors = 0;

  logic [64:0] q[$];
  logic        m_half;
  logic [31:0] m_held;
  logic        m_ovf;
  logic        m_unf;

  ss_src_pack_fifo #(.AW(AW), .AE_LEVEL(2), .AF_FREE(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .m_reset1(m_reset1),
    .ss_xfer(ss_xfer), .ss_last(ss_last), .wbs_dat_o(wbs_dat_o),
    .ss_stop(ss_stop), .m_src_getn(m_src_getn), .m_src(m_src),
    .m_src_last(m_src_last), .m_src_empty(m_src_empty),
    .m_src_almost_empty(m_src_almost_empty), .level(level),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    q.delete();
    m_half = 1'b0;
    m_held = 32'h0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic xf, input logic ls, input logic [31:0] d,
                      input logic gn, input logic r1);
    logic        popped;
    logic        has_wr;
    logic [64:0] e;
    ss_xfer = xf; ss_last = ls; wbs_dat_o = d; m_src_getn = gn; m_reset1 = r1;
    popped = 1'b0; has_wr = 1'b0; e = '0;
    if (r1) begin
      model_clear();
    end else begin
      if (!gn) begin
        if (q.size() == 0) m_unf = 1'b1;
        else popped = 1'b1;
      end
      if (xf) begin
        if (m_half) begin
          e = {d, m_held, ls}; has_wr = 1'b1; m_half = 1'b0;
        end else if (ls) begin
          e = {32'h0, d, 1'b1}; has_wr = 1'b1;
        end else begin
          m_held = d; m_half = 1'b1;
        end
      end
      if (popped) void'(q.pop_front());
      if (has_wr) begin
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_clear();
    wb_rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ss_stop !== 1'b1) begin errors++; $display("FAIL rst_stop got %b exp 1", ss_stop); end
    checks++; if (m_src_empty !== 1'b1 || m_src_almost_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b/%b exp 1/1", m_src_empty, m_src_almost_empty); end
    checks++; if (level !== 5'd0 || m_src !== 64'h0 || m_src_last !== 1'b0) begin errors++; $display("FAIL rst_out level %0d m_src %h last %b exp 0/0/0", level, m_src, m_src_last); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL rst_sticky got %b/%b exp 0/0", ovf, unf); end
    wb_rst_i = 1'b0;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++; if (ss_stop !== 1'b0) begin errors++; $display("FAIL rst_release_stop got %b exp 0", ss_stop); end
    checks++; if (m_src_empty !== 1'b1 || level !== 5'd0 || ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL rst_idle empty %b level %0d ovf %b unf %b", m_src_empty, level, ovf, unf); end
  endtask

  task automatic test_pair();
    step(1, 0, 32'h11111111, 1, 0);
    checks++; if (m_src_empty !== 1'b1) begin errors++; $display("FAIL pair_half_empty got %b exp 1", m_src_empty); end
    step(1, 1, 32'h22222222, 1, 0);
    checks++; if (m_src !== 64'h22222222_11111111 || m_src_last !== 1'b1) begin errors++; $display("FAIL pair_head got %h/%b exp 2222222211111111/1", m_src, m_src_last); end
    checks++; if (level !== 5'd1 || m_src_empty !== 1'b0) begin errors++; $display("FAIL pair_level got %0d/%b exp 1/0", level, m_src_empty); end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    checks++; if (m_src_empty !== 1'b1 || level !== 5'd0 || unf !== 1'b0) begin errors++; $display("FAIL pair_pop empty %b level %0d unf %b exp 1/0/0", m_src_empty, level, unf); end
  endtask

  task automatic test_odd();
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    step(1, 0, a, 1, 0);
    step(1, 0, b, 1, 0);
    step(1, 1, c, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++; if (level !== 5'd2 || m_src_almost_empty !== 1'b1) begin errors++; $display("FAIL odd_level got %0d ae %b exp 2/1", level, m_src_almost_empty); end
    checks++; if (m_src !== {b, a} || m_src_last !== 1'b0) begin errors++; $display("FAIL odd_head0 got %h/%b exp %h/0", m_src, m_src_last, {b, a}); end
    step(0, 0, 0, 0, 0);
    checks++; if (m_src !== {32'h0, c} || m_src_last !== 1'b1) begin errors++; $display("FAIL odd_head1 got %h/%b exp %h/1", m_src, m_src_last, {32'h0, c}); end
    step(0, 0, 0, 0, 0);
    checks++; if (m_src_empty !== 1'b1) begin errors++; $display("FAIL odd_drain got %b exp 1", m_src_empty); end
  endtask

  task automatic test_fill();
    int first_stop = -1;
    int max_level = 0;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 60; i++) begin
      step(!ss_stop, ($urandom_range(0, 3) == 0), $urandom, 1, 0);
      if (int'(level) > max_level) max_level = int'(level);
      if (ss_stop && first_stop < 0) first_stop = int'(level);
    end
    checks++; if (first_stop != 14) begin errors++; $display("FAIL fill_stop_level got %0d exp 14", first_stop); end
    checks++; if (max_level > 16 || ovf !== 1'b0) begin errors++; $display("FAIL fill_bound max %0d ovf %b exp <=16/0", max_level, ovf); end
    checks++; if (level !== 5'(q.size())) begin errors++; $display("FAIL fill_model level %0d exp %0d", level, q.size()); end
    for (int i = 0; i < 10 && q.size() < DEPTH; i++) step(1, 1, $urandom, 1, 0);
    checks++; if (level !== 5'd16 || ovf !== 1'b0) begin errors++; $display("FAIL fill_full level %0d ovf %b exp 16/0", level, ovf); end
    step(1, 1, $urandom, 1, 0);
    checks++; if (ovf !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL fill_ovf ovf %b level %0d exp 1/16", ovf, level); end
  endtask

  task automatic test_simul();
    logic [31:0] y;
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 1, $urandom, 1, 0);
    checks++; if (level !== 5'd16 || ss_stop !== 1'b1) begin errors++; $display("FAIL sim_full level %0d stop %b exp 16/1", level, ss_stop); end
    step(1, 1, $urandom, 0, 0);
    checks++; if (level !== 5'd16 || ovf !== 1'b0) begin errors++; $display("FAIL sim_full_rw level %0d ovf %b exp 16/0", level, ovf); end
    checks++; if (m_src !== q[0][64:1] || m_src_last !== q[0][0]) begin errors++; $display("FAIL sim_full_head got %h exp %h", m_src, q[0][64:1]); end
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 0, 0, 0);
    checks++; if (m_src !== q[0][64:1] || level !== 5'd1) begin errors++; $display("FAIL sim_tail got %h/%0d exp %h/1", m_src, level, q[0][64:1]); end
    step(0, 0, 0, 1, 1);
    y = $urandom;
    step(1, 1, y, 0, 0);
    checks++; if (level !== 5'd1 || unf !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL sim_empty_rw level %0d unf %b ovf %b exp 1/1/0", level, unf, ovf); end
    checks++; if (m_src !== {32'h0, y} || m_src_last !== 1'b1) begin errors++; $display("FAIL sim_empty_head got %h/%b exp %h/1", m_src, m_src_last, {32'h0, y}); end
  endtask

  task automatic test_mreset();
    logic [31:0] x, y;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, $urandom, 1, 0);
    step(1, 0, 32'hDEADBEEF, 1, 0);
    checks++; if (level !== 5'd5 || unf !== 1'b1) begin errors++; $display("FAIL mrst_pre level %0d unf %b exp 5/1", level, unf); end
    step(1, 1, 32'hBAD0BAD0, 0, 1);
    checks++; if (level !== 5'd0 || m_src_empty !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0 || ss_stop !== 1'b1) begin errors++; $display("FAIL mrst_clear level %0d empty %b ovf %b unf %b stop %b", level, m_src_empty, ovf, unf, ss_stop); end
    x = $urandom; y = $urandom;
    step(1, 0, x, 1, 0);
    step(1, 1, y, 1, 0);
    checks++; if (m_src !== {y, x} || m_src_last !== 1'b1 || level !== 5'd1) begin errors++; $display("FAIL mrst_repack got %h/%b/%0d exp %h/1/1", m_src, m_src_last, level, {y, x}); end
  endtask

  task automatic test_random();
    int pop_pct;
    logic xf, gn, r1;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      pop_pct = (i < 300) ? 20 : 70;
      xf = !ss_stop && ($urandom_range(0, 9) < 7);
      gn = !($urandom_range(0, 99) < pop_pct);
      r1 = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) xf = 1'b1;
      step(xf, ($urandom_range(0, 3) == 0), $urandom, gn, r1);
      checks++; if (level !== 5'(q.size())) begin errors++; $display("FAIL rnd_level cyc %0d got %0d exp %0d", i, level, q.size()); end
      checks++; if (m_src_empty !== (q.size() == 0) || m_src_almost_empty !== (q.size() <= 2)) begin errors++; $display("FAIL rnd_flags cyc %0d got %b/%b size %0d", i, m_src_empty, m_src_almost_empty, q.size()); end
      checks++; if (ss_stop !== (m_reset1 || (DEPTH - q.size() <= 2))) begin errors++; $display("FAIL rnd_stop cyc %0d got %b size %0d", i, ss_stop, q.size()); end
      checks++; if (ovf !== m_ovf || unf !== m_unf) begin errors++; $display("FAIL rnd_sticky cyc %0d got %b/%b exp %b/%b", i, ovf, unf, m_ovf, m_unf); end
      if (q.size() > 0) begin
        checks++; if (m_src !== q[0][64:1] || m_src_last !== q[0][0]) begin errors++; $display("FAIL rnd_head cyc %0d got %h/%b exp %h/%b", i, m_src, m_src_last, q[0][64:1], q[0][0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_odd();
    test_fill();
    test_simul();
    test_mreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
